multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 58 +++++
 rtl/multicycle_alu_decoder.sv | 36 +++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM states, opcode/funct
// encodings, ALU control codes and the opcode legality helper.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    // The store bit remembers lw vs sw from DECODE so MEMADR never re-reads op.
    typedef struct packed {
        state_e st;
        logic   store;
    } ctrl_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110;
    localparam logic [2:0] AND = 3'b000;
    localparam logic [2:0] OR  = 3'b001;
    localparam logic [2:0] SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_alu_decoder.sv
// ALU control decode: fixed add/sub for address and branch work, funct-driven for R-type.
// funct_bad flags an unknown funct, which still decodes to add.
module multicycle_alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_bad
);

    // Map aluop/funct to the ALU operation code
    always_comb begin
        alu_control = ADD;
        funct_bad   = 1'b0;
        case (aluop)
            ALUOP_ADD: alu_control = ADD;
            ALUOP_SUB: alu_control = SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ADD;
                    FUNCT_SUB: alu_control = SUB;
                    FUNCT_AND: alu_control = AND;
                    FUNCT_OR:  alu_control = OR;
                    FUNCT_SLT: alu_control = SLT;
                    default: begin
                        alu_control = ADD;
                        funct_bad   = 1'b1;
                    end
                endcase
            end
            default: alu_control = ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS subset (lw, sw, R-type, beq, addi, j).
// Outputs decode from the state register; write enables are forced low while in reset.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op
);

    ctrl_state_t state_q, state_d;
    logic        illegal_q, illegal_d;

    logic [1:0]  aluop_s;
    logic        funct_bad_s;
    logic        pc_write_s, branch_s, ir_write_s, mem_write_s, reg_write_s, done_s;

    multicycle_alu_decoder u_alu_dec (
        .aluop       (aluop_s),
        .funct       (funct),
        .alu_control (alu_control),
        .funct_bad   (funct_bad_s)
    );

    // Next-state selection; op is only consulted in DECODE
    always_comb begin
        state_d = state_q;
        case (state_q.st)
            S_FETCH: begin
                if (mem_ready) state_d.st = S_DECODE;
                else           state_d.st = S_FETCH;
            end
            S_DECODE: begin
                state_d.store = (op == OP_SW);
                case (op)
                    OP_LW, OP_SW: state_d.st = S_MEMADR;
                    OP_RTYPE:     state_d.st = S_EXEC;
                    OP_BEQ:       state_d.st = S_BRANCH;
                    OP_ADDI:      state_d.st = S_ADDIEX;
                    OP_J:         state_d.st = S_JUMP;
                    default:      state_d.st = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (state_q.store) state_d.st = S_MEMWR;
                else               state_d.st = S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) state_d.st = S_MEMWB;
                else           state_d.st = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_ready) state_d.st = S_FETCH;
                else           state_d.st = S_MEMWR;
            end
            S_EXEC:   state_d.st = S_ALUWB;
            S_ADDIEX: state_d.st = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d.st = S_FETCH;
            default:  state_d.st = S_FETCH;
        endcase
    end

    // Sticky illegal flag: unknown opcode in DECODE or unknown funct in EXEC
    always_comb begin
        if (state_q.st == S_DECODE && !op_supported(op)) begin
            illegal_d = 1'b1;
        end else if (funct_bad_s) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // State and illegal-flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '{st: S_FETCH, store: 1'b0};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Per-state control decode; anything not set stays at its inactive value
    always_comb begin
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        aluop_s     = ALUOP_ADD;
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        done_s      = 1'b0;
        case (state_q.st)
            S_FETCH: begin
                alu_src_b  = 2'b01;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
                done_s      = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                aluop_s   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop_s   = ALUOP_SUB;
                branch_s  = 1'b1;
                pc_src    = 2'b01;
                done_s    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write_s = 1'b1;
                done_s     = 1'b1;
            end
            default: alu_src_b = 2'b01;
        endcase
    end

    // rst_n gating keeps FETCH from strobing ir_write/pc_en during reset
    assign pc_en      = rst_n & (pc_write_s | (branch_s & zero));
    assign ir_write   = rst_n & ir_write_s;
    assign mem_write  = rst_n & mem_write_s;
    assign reg_write  = rst_n & reg_write_s;
    assign instr_done = rst_n & done_s;
    assign illegal_op = illegal_q;

endmodule
